// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit tracker.
//   commit_lane_t   : one retire lane {valid, pc, instr, wen, wdest, wdata}
//   tracker_state_e : tracker FSM states
//   TRAP_GOOD/BAD   : trap_code values reported with the trap event
// Lane pc/wdata are held at LANE_XLEN bits. Narrower XLEN values are
// zero-extended into the lane and truncated again on the way out.
package difftest_pkg;

  localparam int LANE_XLEN = 64;

  typedef struct packed {
    logic                 valid;
    logic [LANE_XLEN-1:0] pc;
    logic [31:0]          instr;
    logic                 wen;
    logic [4:0]           wdest;
    logic [LANE_XLEN-1:0] wdata;
  } commit_lane_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } tracker_state_e;

  localparam logic [2:0] TRAP_GOOD = 3'd0;
  localparam logic [2:0] TRAP_BAD  = 3'd1;

endpackage

// File: rtl/commit_compactor.sv
// Combinational lane compactor.
//   in_lanes  : raw retire lanes, lane 0 first
//   kill      : lanes to drop even if valid (lanes above the trap lane,
//               or every lane once the tracker is halted)
//   out_lanes : accepted lanes packed into 0..count-1, upper lanes all-zero
//   count     : number of accepted lanes (popcount of valid & ~kill)
// wen is cleared for lanes writing x0 so the checker never sees a write
// to the zero register.
import difftest_pkg::*;

module commit_compactor #(
  parameter int NCOMMIT = 2
) (
  input  commit_lane_t [NCOMMIT-1:0] in_lanes,
  input  logic         [NCOMMIT-1:0] kill,
  output commit_lane_t [NCOMMIT-1:0] out_lanes,
  output logic         [2:0]         count
);

  // Each accepted lane lands at the slot given by how many lanes were
  // accepted below it. The inner compare loop avoids a variable index.
  always_comb begin
    int pos;
    pos       = 0;
    out_lanes = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      if (in_lanes[i].valid && !kill[i]) begin
        for (int j = 0; j < NCOMMIT; j++) begin
          if (j == pos) begin
            out_lanes[j]     = in_lanes[i];
            out_lanes[j].wen = in_lanes[i].wen && (in_lanes[i].wdest != 5'd0);
          end
        end
        pos = pos + 1;
      end
    end
    count = 3'(pos);
  end

endmodule

// File: rtl/difftest_commit_tracker.sv
// Multi-lane retire tracker feeding the difftest commit and trap ports.
//   clk, reset         : clock, asynchronous active-high reset
//   cm_*               : up to NCOMMIT retire events per cycle (flattened, lane 0 in LSBs)
//   a0_val             : architectural x10, sampled on the trap edge
//   out_*              : registered, compacted commit lanes (out_wdest = {3'b0, wdest})
//   trap_valid/code/pc : one-cycle trap event for the halt instruction
//   cycle_cnt          : edges spent in RUN since reset
//   instr_cnt          : instructions accepted since reset
//   halted             : FSM state (1 = HALTED), doubles as the state debug view
// Handshake: cm_valid is a pure per-lane valid with no ready; every valid lane
// presented at an edge while in RUN is consumed at that edge, and nothing is
// ever stalled. All outputs appear one cycle after the sampling edge.
import difftest_pkg::*;

module difftest_commit_tracker #(
  parameter int          NCOMMIT    = 2,
  parameter int          XLEN       = 64,
  parameter logic [31:0] TRAP_INSTR = 32'h0005006b
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCOMMIT-1:0]      cm_valid,
  input  logic [NCOMMIT*XLEN-1:0] cm_pc,
  input  logic [NCOMMIT*32-1:0]   cm_instr,
  input  logic [NCOMMIT-1:0]      cm_wen,
  input  logic [NCOMMIT*5-1:0]    cm_wdest,
  input  logic [NCOMMIT*XLEN-1:0] cm_wdata,
  input  logic [XLEN-1:0]         a0_val,
  output logic [NCOMMIT-1:0]      out_valid,
  output logic [NCOMMIT*XLEN-1:0] out_pc,
  output logic [NCOMMIT*32-1:0]   out_instr,
  output logic [NCOMMIT-1:0]      out_wen,
  output logic [NCOMMIT*8-1:0]    out_wdest,
  output logic [NCOMMIT*XLEN-1:0] out_wdata,
  output logic                    trap_valid,
  output logic [2:0]              trap_code,
  output logic [XLEN-1:0]         trap_pc,
  output logic [63:0]             cycle_cnt,
  output logic [63:0]             instr_cnt,
  output logic                    halted
);

  tracker_state_e               state;
  commit_lane_t [NCOMMIT-1:0]   raw_lanes;
  commit_lane_t [NCOMMIT-1:0]   packed_lanes;
  commit_lane_t [NCOMMIT-1:0]   out_q;
  logic         [NCOMMIT-1:0]   kill;
  logic         [2:0]           accept_cnt;
  logic                         trap_hit;
  logic         [XLEN-1:0]      trap_lane_pc;

  // Unflatten the input buses into lane structs.
  always_comb begin
    raw_lanes = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      raw_lanes[i].valid = cm_valid[i];
      raw_lanes[i].pc    = LANE_XLEN'(cm_pc[i*XLEN +: XLEN]);
      raw_lanes[i].instr = cm_instr[i*32 +: 32];
      raw_lanes[i].wen   = cm_wen[i];
      raw_lanes[i].wdest = cm_wdest[i*5 +: 5];
      raw_lanes[i].wdata = LANE_XLEN'(cm_wdata[i*XLEN +: XLEN]);
    end
  end

  // The lowest valid halt instruction is the trap lane; it still commits,
  // every lane above it is killed. Once halted, every lane is killed.
  always_comb begin
    trap_hit     = 1'b0;
    trap_lane_pc = '0;
    kill         = '0;
    if (state == HALTED) begin
      kill = '1;
    end else begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (trap_hit) begin
          kill[i] = 1'b1;
        end else if (cm_valid[i] && (cm_instr[i*32 +: 32] == TRAP_INSTR)) begin
          trap_hit     = 1'b1;
          trap_lane_pc = cm_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  commit_compactor #(
    .NCOMMIT (NCOMMIT)
  ) u_compactor (
    .in_lanes  (raw_lanes),
    .kill      (kill),
    .out_lanes (packed_lanes),
    .count     (accept_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      out_q      <= '0;
      trap_valid <= 1'b0;
      trap_code  <= TRAP_GOOD;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          out_q      <= packed_lanes;
          cycle_cnt  <= cycle_cnt + 64'd1;
          instr_cnt  <= instr_cnt + 64'(accept_cnt);
          trap_valid <= trap_hit;
          if (trap_hit) begin
            trap_code <= (a0_val == '0) ? TRAP_GOOD : TRAP_BAD;
            trap_pc   <= trap_lane_pc;
            state     <= HALTED;
          end
        end
        HALTED: begin
          // Counters and trap_code/trap_pc hold; commit lanes stay silent.
          out_q      <= '0;
          trap_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign halted = (state == HALTED);

  // Flatten the registered lanes back onto the output buses.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_instr = '0;
    out_wen   = '0;
    out_wdest = '0;
    out_wdata = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      out_valid[i]               = out_q[i].valid;
      out_pc[i*XLEN +: XLEN]     = out_q[i].pc[XLEN-1:0];
      out_instr[i*32 +: 32]      = out_q[i].instr;
      out_wen[i]                 = out_q[i].wen;
      out_wdest[i*8 +: 8]        = {3'b000, out_q[i].wdest};
      out_wdata[i*XLEN +: XLEN]  = out_q[i].wdata[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Bench for difftest_commit_tracker with NCOMMIT=2, XLEN=64.
// Directed vector table for compaction plus hand-written reset and trap sequences.
module tb_difftest_commit_tracker;

  localparam logic [31:0] TRAP = 32'h0005006b;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic         clk;
  logic         reset;
  logic [1:0]   cm_valid;
  logic [127:0] cm_pc;
  logic [63:0]  cm_instr;
  logic [1:0]   cm_wen;
  logic [9:0]   cm_wdest;
  logic [127:0] cm_wdata;
  logic [63:0]  a0_val;
  logic [1:0]   out_valid;
  logic [127:0] out_pc;
  logic [63:0]  out_instr;
  logic [1:0]   out_wen;
  logic [15:0]  out_wdest;
  logic [127:0] out_wdata;
  logic         trap_valid;
  logic [2:0]   trap_code;
  logic [63:0]  trap_pc;
  logic [63:0]  cycle_cnt;
  logic [63:0]  instr_cnt;
  logic         halted;

  int checks;
  int failures;
  logic [63:0] exp_cycle;
  logic [63:0] exp_instr;

  difftest_commit_tracker #(
    .NCOMMIT    (2),
    .XLEN       (64),
    .TRAP_INSTR (32'h0005006b)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cm_valid   (cm_valid),
    .cm_pc      (cm_pc),
    .cm_instr   (cm_instr),
    .cm_wen     (cm_wen),
    .cm_wdest   (cm_wdest),
    .cm_wdata   (cm_wdata),
    .a0_val     (a0_val),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_wen    (out_wen),
    .out_wdest  (out_wdest),
    .out_wdata  (out_wdata),
    .trap_valid (trap_valid),
    .trap_code  (trap_code),
    .trap_pc    (trap_pc),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
    .halted     (halted)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [63:0] pc0, pc1;
    logic [31:0] in0, in1;
    logic [1:0]  wen;
    logic [4:0]  wd0, wd1;
    logic [63:0] d0, d1;
    logic [1:0]  e_valid;
    logic [63:0] e_pc0, e_pc1;
    logic [31:0] e_in0, e_in1;
    logic [1:0]  e_wen;
    logic [15:0] e_wdest;
    logic [63:0] e_d0, e_d1;
    int          e_inc;
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] w,
                       input logic [4:0] wd0, input logic [4:0] wd1,
                       input logic [63:0] d0, input logic [63:0] d1);
    cm_valid = v;
    cm_pc    = {p1, p0};
    cm_instr = {i1, i0};
    cm_wen   = w;
    cm_wdest = {wd1, wd0};
    cm_wdata = {d1, d0};
  endtask

  task automatic idle();
    drive(2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
  endtask

  // Reset pulse of one cycle, released on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    idle();
    a0_val = 64'h0;
    reset  = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    exp_cycle = 64'h0;
    exp_instr = 64'h0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Trap on lane 0 with lane 1 also valid, after 10 idle cycles, then
  // keep retiring for post cycles to show the tracker stays frozen.
  task automatic trap_seq(input string tag, input logic [63:0] a0, input logic [2:0] exp_code,
                          input int post);
    pulse_reset();
    repeat (10) @(negedge clk);
    chk({tag, "_pre_cycle"}, cycle_cnt, 64'd10);
    a0_val = a0;
    drive(2'b11, 64'h80000100, 64'h80000104, TRAP, NOP, 2'b11, 5'd10, 5'd11, 64'h5, 64'h6);
    @(negedge clk);
    chk({tag, "_valid"},      {62'h0, out_valid}, 64'h1);
    chk({tag, "_pc0"},        out_pc[63:0], 64'h80000100);
    chk({tag, "_pc1"},        out_pc[127:64], 64'h0);
    chk({tag, "_wdata1"},     out_wdata[127:64], 64'h0);
    chk({tag, "_trap_valid"}, {63'h0, trap_valid}, 64'h1);
    chk({tag, "_trap_code"},  {61'h0, trap_code}, {61'h0, exp_code});
    chk({tag, "_trap_pc"},    trap_pc, 64'h80000100);
    chk({tag, "_cycle"},      cycle_cnt, 64'd11);
    chk({tag, "_instr"},      instr_cnt, 64'd1);
    chk({tag, "_halted"},     {63'h0, halted}, 64'h1);
    a0_val = 64'h0;
    drive(2'b11, 64'h80000108, 64'h8000010c, NOP, TRAP, 2'b11, 5'd1, 5'd2, 64'h7, 64'h8);
    for (int k = 0; k < post; k++) begin
      @(negedge clk);
      chk($sformatf("%s_post%0d_valid", tag, k), {62'h0, out_valid}, 64'h0);
      chk($sformatf("%s_post%0d_trap", tag, k), {63'h0, trap_valid}, 64'h0);
    end
    chk({tag, "_frozen_cycle"},  cycle_cnt, 64'd11);
    chk({tag, "_frozen_instr"},  instr_cnt, 64'd1);
    chk({tag, "_frozen_halted"}, {63'h0, halted}, 64'h1);
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    exp_cycle = 64'h0;
    exp_instr = 64'h0;
    reset     = 1'b1;
    a0_val    = 64'h0;
    idle();

    //               valid  pc0           pc1           in0            in1            wen    wd0    wd1    d0                     d1
    //               e_valid e_pc0        e_pc1         e_in0          e_in1          e_wen  e_wdest  e_d0                  e_d1   inc
    vecs[0] = '{2'b11, 64'h80000000, 64'h80000004, 32'h00100093, 32'h00200113, 2'b11, 5'd1, 5'd2, 64'h11, 64'h22,
                2'b11, 64'h80000000, 64'h80000004, 32'h00100093, 32'h00200113, 2'b11, 16'h0201, 64'h11, 64'h22, 2};
    vecs[1] = '{2'b10, 64'h12345678, 64'h80000008, 32'hdeadbeef, 32'h00300193, 2'b11, 5'd3, 5'd4, 64'haa, 64'hbb,
                2'b01, 64'h80000008, 64'h0, 32'h00300193, 32'h0, 2'b01, 16'h0004, 64'hbb, 64'h0, 1};
    vecs[2] = '{2'b01, 64'h8000000c, 64'h55, NOP, 32'h77, 2'b11, 5'd0, 5'd9, 64'hdead, 64'h99,
                2'b01, 64'h8000000c, 64'h0, NOP, 32'h0, 2'b00, 16'h0000, 64'hdead, 64'h0, 1};
    vecs[3] = '{2'b00, 64'h1, 64'h2, TRAP, TRAP, 2'b11, 5'd5, 5'd6, 64'h7, 64'h8,
                2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 2'b00, 16'h0000, 64'h0, 64'h0, 0};
    vecs[4] = '{2'b11, 64'h80000010, 64'h80000014, NOP, NOP, 2'b10, 5'd5, 5'd0, 64'h1, 64'h2,
                2'b11, 64'h80000010, 64'h80000014, NOP, NOP, 2'b00, 16'h0005, 64'h1, 64'h2, 2};
    vecs[5] = '{2'b01, 64'h80000018, 64'h0, 32'h01f00f93, 32'h0, 2'b01, 5'd31, 5'd0, 64'hffffffffffffffff, 64'h0,
                2'b01, 64'h80000018, 64'h0, 32'h01f00f93, 32'h0, 2'b01, 16'h001f, 64'hffffffffffffffff, 64'h0, 1};
    vecs[6] = '{2'b10, 64'h5, 64'h8000001c, TRAP, NOP, 2'b10, 5'd0, 5'd7, 64'h0, 64'h70,
                2'b01, 64'h8000001c, 64'h0, NOP, 32'h0, 2'b01, 16'h0007, 64'h70, 64'h0, 1};

    // Reset state, observed while reset is still held.
    @(posedge clk);
    #1;
    chk("rst_valid",  {62'h0, out_valid}, 64'h0);
    chk("rst_pc",     out_pc[63:0] | out_pc[127:64], 64'h0);
    chk("rst_trap",   {63'h0, trap_valid}, 64'h0);
    chk("rst_cycle",  cycle_cnt, 64'h0);
    chk("rst_instr",  instr_cnt, 64'h0);
    chk("rst_halted", {63'h0, halted}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Compaction vectors.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].pc0, vecs[i].pc1, vecs[i].in0, vecs[i].in1, vecs[i].wen,
            vecs[i].wd0, vecs[i].wd1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      exp_cycle = exp_cycle + 64'd1;
      exp_instr = exp_instr + 64'(vecs[i].e_inc);
      chk($sformatf("v%0d_valid", i),  {62'h0, out_valid}, {62'h0, vecs[i].e_valid});
      chk($sformatf("v%0d_pc0", i),    out_pc[63:0], vecs[i].e_pc0);
      chk($sformatf("v%0d_pc1", i),    out_pc[127:64], vecs[i].e_pc1);
      chk($sformatf("v%0d_instr", i),  out_instr, {vecs[i].e_in1, vecs[i].e_in0});
      chk($sformatf("v%0d_wen", i),    {62'h0, out_wen}, {62'h0, vecs[i].e_wen});
      chk($sformatf("v%0d_wdest", i),  {48'h0, out_wdest}, {48'h0, vecs[i].e_wdest});
      chk($sformatf("v%0d_wdata0", i), out_wdata[63:0], vecs[i].e_d0);
      chk($sformatf("v%0d_wdata1", i), out_wdata[127:64], vecs[i].e_d1);
      chk($sformatf("v%0d_icnt", i),   instr_cnt, exp_instr);
      chk($sformatf("v%0d_ccnt", i),   cycle_cnt, exp_cycle);
      chk($sformatf("v%0d_trap", i),   {63'h0, trap_valid}, 64'h0);
      chk($sformatf("v%0d_halted", i), {63'h0, halted}, 64'h0);
    end

    // Asynchronous reset in the middle of a cycle with live outputs.
    drive(vecs[0].valid, vecs[0].pc0, vecs[0].pc1, vecs[0].in0, vecs[0].in1, vecs[0].wen,
          vecs[0].wd0, vecs[0].wd1, vecs[0].d0, vecs[0].d1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {62'h0, out_valid}, 64'h0);
    chk("mid_rst_pc0",   out_pc[63:0], 64'h0);
    chk("mid_rst_cycle", cycle_cnt, 64'h0);
    chk("mid_rst_instr", instr_cnt, 64'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cycle", cycle_cnt, 64'd1);
    chk("post_rst_instr", instr_cnt, 64'd0);
    chk("post_rst_valid", {62'h0, out_valid}, 64'h0);

    // Good trap then 20 frozen cycles; bad trap then 3 frozen cycles.
    trap_seq("good", 64'h0, 3'd0, 20);
    trap_seq("bad", 64'h5, 3'd1, 3);

    // Trap on lane 1 with lane 0 valid: both commit.
    pulse_reset();
    @(negedge clk);
    drive(2'b11, 64'h80000200, 64'h80000204, NOP, TRAP, 2'b01, 5'd3, 5'd0, 64'h33, 64'h44);
    @(negedge clk);
    chk("t1_valid",   {62'h0, out_valid}, 64'h3);
    chk("t1_pc1",     out_pc[127:64], 64'h80000204);
    chk("t1_trap",    {63'h0, trap_valid}, 64'h1);
    chk("t1_trap_pc", trap_pc, 64'h80000204);
    chk("t1_code",    {61'h0, trap_code}, 64'h0);
    chk("t1_cycle",   cycle_cnt, 64'd2);
    chk("t1_instr",   instr_cnt, 64'd2);
    idle();
    @(negedge clk);
    chk("t1_trap_pulse", {63'h0, trap_valid}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
